// File: rtl/match_pkg.sv
// Shared types and defaults for the match lock tracker.
package match_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/match_lock_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear; used for lock and stats counts.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count register: clear wins over increment, value sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/match_lock_tracker.sv
// Qualifies comparator match runs into a registered lock status with miss-tolerant hold.
// Optional feature macro: MATCH_STATS_EN adds match_total / miss_total counters.
module match_lock_tracker
    import match_pkg::*;
#(
    parameter int RUN_LEN    = 4,
    parameter int MISS_LIMIT = 2,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         match_valid,
    input  logic                         match,
    input  logic                         clear,
    output logic                         locked,
    output logic                         lock_pulse,
    output logic [1:0]                   state,
    output logic [$clog2(RUN_LEN+1)-1:0] run_cnt,
    output logic [CNT_W-1:0]             lock_count
`ifdef MATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]             match_total,
    output logic [CNT_W-1:0]             miss_total
`endif
);

    localparam int RW = $clog2(RUN_LEN + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);
    localparam logic [RW-1:0] RUN_LEN_C    = RW'(RUN_LEN);
    localparam logic [MW-1:0] MISS_LIMIT_C = MW'(MISS_LIMIT);

    if (RUN_LEN < 1 || MISS_LIMIT < 1) begin : g_bad_params
        $error("match_lock_tracker: RUN_LEN and MISS_LIMIT must both be >= 1");
    end

    state_t        state_r;
    logic [RW-1:0] run_cnt_r;
    logic [MW-1:0] miss_r;
    logic          locked_r;
    logic          lock_pulse_r;
    logic          acquire_s;
    logic          sample_s;

    assign sample_s = match_valid & ~clear;

    // Entering LOCKED from SEARCH or VERIFY is an acquisition; HOLD recovery is not.
    assign acquire_s = sample_s & match &
                       (((state_r == SEARCH) && (RUN_LEN == 1)) ||
                        ((state_r == VERIFY) && ((run_cnt_r + RW'(1)) == RUN_LEN_C)));

    // Lock FSM with run/miss counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= SEARCH;
            run_cnt_r    <= {RW{1'b0}};
            miss_r       <= {MW{1'b0}};
            locked_r     <= 1'b0;
            lock_pulse_r <= 1'b0;
        end else if (clear) begin
            state_r      <= SEARCH;
            run_cnt_r    <= {RW{1'b0}};
            miss_r       <= {MW{1'b0}};
            locked_r     <= 1'b0;
            lock_pulse_r <= 1'b0;
        end else if (!match_valid) begin
            lock_pulse_r <= 1'b0;
        end else begin
            lock_pulse_r <= acquire_s;
            case (state_r)
                SEARCH: begin
                    if (match) begin
                        run_cnt_r <= RW'(1);
                        if (RUN_LEN == 1) begin
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            state_r  <= VERIFY;
                        end
                    end else begin
                        run_cnt_r <= {RW{1'b0}};
                    end
                end
                VERIFY: begin
                    if (match) begin
                        run_cnt_r <= run_cnt_r + RW'(1);
                        if ((run_cnt_r + RW'(1)) == RUN_LEN_C) begin
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            state_r  <= VERIFY;
                        end
                    end else begin
                        state_r   <= SEARCH;
                        run_cnt_r <= {RW{1'b0}};
                    end
                end
                LOCKED: begin
                    if (match) begin
                        state_r <= LOCKED;
                    end else if (MISS_LIMIT == 1) begin
                        state_r   <= SEARCH;
                        run_cnt_r <= {RW{1'b0}};
                        miss_r    <= {MW{1'b0}};
                        locked_r  <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                        miss_r  <= MW'(1);
                    end
                end
                HOLD: begin
                    if (match) begin
                        state_r <= LOCKED;
                        miss_r  <= {MW{1'b0}};
                    end else if ((miss_r + MW'(1)) == MISS_LIMIT_C) begin
                        state_r   <= SEARCH;
                        run_cnt_r <= {RW{1'b0}};
                        miss_r    <= {MW{1'b0}};
                        locked_r  <= 1'b0;
                    end else begin
                        miss_r <= miss_r + MW'(1);
                    end
                end
                default: begin
                    state_r   <= SEARCH;
                    run_cnt_r <= {RW{1'b0}};
                    miss_r    <= {MW{1'b0}};
                    locked_r  <= 1'b0;
                end
            endcase
        end
    end

    assign state      = state_r;
    assign run_cnt    = run_cnt_r;
    assign locked     = locked_r;
    assign lock_pulse = lock_pulse_r;

    sat_counter #(.W(CNT_W)) u_lock_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (acquire_s),
        .q     (lock_count)
    );

`ifdef MATCH_STATS_EN
    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (sample_s & match),
        .q     (match_total)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (sample_s & ~match),
        .q     (miss_total)
    );
`endif

endmodule

// File: tb/tb_match_lock_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural lock model.
module tb_match_lock_tracker;

    localparam int RUN_LEN    = 4;
    localparam int MISS_LIMIT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       match_valid = 1'b0;
    logic       match = 1'b0;
    logic       clear = 1'b0;

    logic       locked, lock_pulse, locked2, lock_pulse2;
    logic [1:0] state, state2;
    logic [2:0] run_cnt, run_cnt2;
    logic [7:0] lock_count;
    logic [1:0] lock_count2;
`ifdef MATCH_STATS_EN
    logic [7:0] match_total, miss_total;
    logic [1:0] match_total2, miss_total2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: run length, lock flag, miss streak, acquisition tally.
    int m_run = 0, m_miss = 0, m_acq = 0, m_mt = 0, m_mm = 0;
    bit m_locked = 1'b0, m_pulse = 1'b0;

    always #5 clk = ~clk;

    match_lock_tracker #(.RUN_LEN(RUN_LEN), .MISS_LIMIT(MISS_LIMIT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .match_valid(match_valid), .match(match), .clear(clear),
        .locked(locked), .lock_pulse(lock_pulse), .state(state), .run_cnt(run_cnt),
        .lock_count(lock_count)
`ifdef MATCH_STATS_EN
        , .match_total(match_total), .miss_total(miss_total)
`endif
    );

    match_lock_tracker #(.RUN_LEN(RUN_LEN), .MISS_LIMIT(MISS_LIMIT), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .match_valid(match_valid), .match(match), .clear(clear),
        .locked(locked2), .lock_pulse(lock_pulse2), .state(state2), .run_cnt(run_cnt2),
        .lock_count(lock_count2)
`ifdef MATCH_STATS_EN
        , .match_total(match_total2), .miss_total(miss_total2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_miss = 0; m_acq = 0; m_mt = 0; m_mm = 0;
        m_locked = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic m, input logic c);
        m_pulse = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (m) m_mt++; else m_mm++;
            if (!m_locked) begin
                if (m) begin
                    m_run++;
                    if (m_run == RUN_LEN) begin
                        m_locked = 1'b1;
                        m_pulse  = 1'b1;
                        m_acq++;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (m) begin
                m_miss = 0;
            end else begin
                m_miss++;
                if (m_miss == MISS_LIMIT) begin
                    m_locked = 1'b0;
                    m_run    = 0;
                    m_miss   = 0;
                end
            end
        end
    endtask

    function automatic int exp_state();
        if (m_locked) return (m_miss == 0) ? 2 : 3;
        return (m_run == 0) ? 0 : 1;
    endfunction

    task automatic check_all();
        chk("state",       32'(state),       32'(exp_state()));
        chk("run_cnt",     32'(run_cnt),     32'(m_run));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("lock_pulse",  32'(lock_pulse),  32'(m_pulse));
        chk("lock_count",  32'(lock_count),  32'(sat(m_acq, 255)));
        chk("state_w2",    32'(state2),      32'(exp_state()));
        chk("lock_count2", 32'(lock_count2), 32'(sat(m_acq, 3)));
`ifdef MATCH_STATS_EN
        chk("match_total",  32'(match_total),  32'(sat(m_mt, 255)));
        chk("miss_total",   32'(miss_total),   32'(sat(m_mm, 255)));
        chk("match_total2", 32'(match_total2), 32'(sat(m_mt, 3)));
        chk("miss_total2",  32'(miss_total2),  32'(sat(m_mm, 3)));
`endif
    endtask

    // Drive one sample after a falling edge, then check one step after the rising edge.
    task automatic step(input logic v, input logic m, input logic c);
        match_valid = v; match = m; clear = c;
        @(posedge clk);
        model_update(v, m, c);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        int exp_w2 [5] = '{1, 2, 3, 3, 3};
        int exp_t1 [4] = '{1, 1, 1, 2};

        #2;
        chk("rst_state", 32'(state), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: four matches acquire lock
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("t1_state", 32'(state), 32'(exp_t1[i]));
        end
        chk("t1_pulse", 32'(lock_pulse), 32'd1);
        chk("t1_count", 32'(lock_count), 32'd1);

        // 2: a miss mid-verify restarts the run
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_search", 32'(state), 32'd0);
        chk("t2_run0", 32'(run_cnt), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("t2_locked", 32'(locked), 32'd1);
        chk("t2_count", 32'(lock_count), 32'd1);

        // 3: hold and recovery, then drop
        step(1'b1, 1'b0, 1'b0);
        chk("t3_hold", 32'(state), 32'd3);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_recover", 32'(state), 32'd2);
        chk("t3_nopulse", 32'(lock_pulse), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_search", 32'(state), 32'd0);
        chk("t3_unlocked", 32'(locked), 32'd0);
        chk("t3_count", 32'(lock_count), 32'd1);

        // 4: invalid samples freeze everything
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'b0);
        chk("t4_state", 32'(state), 32'd2);
        chk("t4_run", 32'(run_cnt), 32'd4);
        chk("t4_count", 32'(lock_count), 32'd2);

        // 5: 2-bit lock counter saturation, then clear
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
            chk("t5_count2", 32'(lock_count2), 32'(exp_w2[k]));
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("t5_clr_count2", 32'(lock_count2), 32'd0);
        chk("t5_clr_state", 32'(state2), 32'd0);

        // Stats: 6 matches and 3 misses
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
`ifdef MATCH_STATS_EN
        chk("t6_match_total", 32'(match_total), 32'd6);
        chk("t6_miss_total", 32'(miss_total), 32'd3);
`endif

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 99) == 0));
        end

        // 6: asynchronous reset mid-verify takes effect without a clock edge
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_pre_run", 32'(run_cnt), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_run", 32'(run_cnt), 32'd0);
        chk("t6_async_state", 32'(state), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
